// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract arbiter: op encodings, FSM states
// and the add/sub/SLT evaluation used on the accept cycle.
package addsub_pkg;

  localparam int W = 32;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  typedef struct packed {
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         cout;
  } alu_res_t;

  // ctl0 inverts B and injects the carry; ctl1 selects the raw sign bit (SLT).
  // Encoding 2'b10 has ctl0=0, so it evaluates as ADD with a sign-bit result
  // suppressed below to keep it a plain ADD.
  function automatic alu_res_t alu_f(input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     input logic [1:0]   op);
    alu_res_t       r;
    logic [W-1:0]   b_eff;
    logic [W:0]     sum;
    logic           ctl0;
    logic           slt;
    ctl0  = op[0];
    slt   = (op == OP_SLT);
    b_eff = ctl0 ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, ctl0};
    r.cout     = sum[W];
    r.overflow = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
    r.result   = slt ? {{(W-1){1'b0}}, sum[W-1]} : sum[W-1:0];
    r.zero     = (r.result == {W{1'b0}});
    return r;
  endfunction

endpackage

// File: rtl/addsub_rr_arb.sv
// Combinational round-robin picker: first request at or after the pointer,
// wrapping modulo NREQ. The pointer register lives in the parent.
module addsub_rr_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  logic [NREQ-1:0] rot_s;
  logic            found_s;
  logic [IDW:0]    sum_s;

  // Rotate so bit 0 is the pointer position, take the first set bit, map back.
  always_comb begin
    rot_s   = NREQ'({req_i, req_i} >> ptr_i);
    idx_o   = '0;
    found_s = 1'b0;
    sum_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (en_i && !found_s && rot_s[k]) begin
        found_s = 1'b1;
        sum_s   = {1'b0, ptr_i} + (IDW+1)'(k);
        if (sum_s >= (IDW+1)'(NREQ)) begin
          sum_s = sum_s - (IDW+1)'(NREQ);
        end else begin
          sum_s = sum_s;
        end
        idx_o = IDW'(sum_s);
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      gnt_o = NREQ'(1) << idx_o;
    end else begin
      gnt_o = '0;
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin shared 32-bit ADD/SUB/SLT unit with one registered result slot.
// Optional per-requester grant and stall counters: ADDSUB_ARBITER_STATS_EN.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  input  logic [2*NREQ-1:0] req_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_result,
  output logic              resp_zero,
  output logic              resp_overflow,
  output logic              resp_cout
`ifdef ADDSUB_ARBITER_STATS_EN
 ,output logic [16*NREQ-1:0] stat_grants,
  output logic [15:0]        stat_stall
`endif
);

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_d;
  logic            resp_valid_q;
  logic [IDW-1:0]  resp_id_q;
  alu_res_t        res_q;

  logic            grant_en_s;
  logic [NREQ-1:0] gnt_s;
  logic [IDW-1:0]  win_s;
  logic [W-1:0]    a_s;
  logic [W-1:0]    b_s;
  logic [1:0]      op_s;
  alu_res_t        alu_s;

  // A grant is possible from IDLE, or from FULL when the held result drains.
  always_comb begin
    case (state_q)
      IDLE:    grant_en_s = reset_n;
      FULL:    grant_en_s = reset_n & resp_ready;
      default: grant_en_s = 1'b0;
    endcase
  end

  addsub_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .en_i  (grant_en_s),
    .gnt_o (gnt_s),
    .idx_o (win_s)
  );

  assign req_ready = gnt_s;

  // Steer the winner's operands into the shared datapath.
  always_comb begin
    a_s  = '0;
    b_s  = '0;
    op_s = OP_ADD;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_s[k]) begin
        a_s  = req_a[W*k +: W];
        b_s  = req_b[W*k +: W];
        op_s = req_op[2*k +: 2];
      end else begin
        op_s = op_s;
      end
    end
    alu_s = alu_f(a_s, b_s, op_s);
  end

  // Pointer advances past the winner, wrapping at NREQ.
  always_comb begin
    if (win_s == IDW'(NREQ-1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = win_s + IDW'(1);
    end
  end

  // Result slot FSM: a grant always loads; an undrained slot holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      res_q        <= '0;
    end else if (|gnt_s) begin
      state_q      <= FULL;
      ptr_q        <= ptr_d;
      resp_valid_q <= 1'b1;
      resp_id_q    <= win_s;
      res_q        <= alu_s;
    end else begin
      case (state_q)
        FULL: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
          end else begin
            state_q      <= FULL;
            resp_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_result   = res_q.result;
  assign resp_zero     = res_q.zero;
  assign resp_overflow = res_q.overflow;
  assign resp_cout     = res_q.cout;

`ifdef ADDSUB_ARBITER_STATS_EN
  logic [15:0] grant_cnt_q [NREQ];
  logic [15:0] stall_cnt_q;

  // Saturating grant and back-pressure counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREQ; k++) begin
        grant_cnt_q[k] <= 16'h0000;
      end
      stall_cnt_q <= 16'h0000;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (gnt_s[k] && (grant_cnt_q[k] != 16'hFFFF)) begin
          grant_cnt_q[k] <= grant_cnt_q[k] + 16'd1;
        end
      end
      if (resp_valid_q && !resp_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  // Flatten the per-requester counters onto the output bus.
  always_comb begin
    stat_grants = '0;
    for (int k = 0; k < NREQ; k++) begin
      stat_grants[16*k +: 16] = grant_cnt_q[k];
    end
  end

  assign stat_stall = stall_cnt_q;
`endif

endmodule
